// File: rtl/fp3d_geom_pkg.sv
//------------------------------------------------------------------------------
// Module  : fp3d_geom_pkg
// Brief   : Shared geometry types and widths for the fp-3D triangle setup path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fp3d_geom_pkg;

  localparam int MAX_BIT_WIDTH = 6;
  localparam int VEC_W         = MAX_BIT_WIDTH + 1;
  localparam int AREA_W        = 2 * MAX_BIT_WIDTH + 3;

  typedef struct packed {
    logic [MAX_BIT_WIDTH-1:0] x;
    logic [MAX_BIT_WIDTH-1:0] y;
  } point_t;

  typedef struct packed {
    logic signed [VEC_W-1:0] x;
    logic signed [VEC_W-1:0] y;
  } vec_t;

  typedef enum logic [1:0] {
    EDGE_AB = 2'd0,
    EDGE_BC = 2'd1,
    EDGE_CA = 2'd2
  } edge_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    AREA = 2'd2,
    EMIT = 2'd3
  } seq_state_t;

  function automatic logic signed [AREA_W-1:0] sext_area(input logic signed [VEC_W-1:0] v);
    return {{(AREA_W-VEC_W){v[VEC_W-1]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_vec_sequencer_if.sv
//------------------------------------------------------------------------------
// Module  : edge_vec_sequencer_if
// Brief   : Triangle-in / edge-vector-out handshake bundle for edge_vec_sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface edge_vec_sequencer_if;
  import fp3d_geom_pkg::*;

  logic                     tri_valid_in;
  logic                     tri_ready_out;
  logic [MAX_BIT_WIDTH-1:0] v0_x_in, v0_y_in;
  logic [MAX_BIT_WIDTH-1:0] v1_x_in, v1_y_in;
  logic [MAX_BIT_WIDTH-1:0] v2_x_in, v2_y_in;
  logic                     vec_valid_out;
  logic                     vec_ready_in;
  logic signed [VEC_W-1:0]  vec_x_out;
  logic signed [VEC_W-1:0]  vec_y_out;
  edge_idx_t                edge_idx_out;
  logic                     edge_last_out;
  logic                     busy_out;
  logic                     culled_out;

  modport master (
    output tri_valid_in, v0_x_in, v0_y_in, v1_x_in, v1_y_in, v2_x_in, v2_y_in, vec_ready_in,
    input  tri_ready_out, vec_valid_out, vec_x_out, vec_y_out, edge_idx_out,
           edge_last_out, busy_out, culled_out
  );

  modport slave (
    input  tri_valid_in, v0_x_in, v0_y_in, v1_x_in, v1_y_in, v2_x_in, v2_y_in, vec_ready_in,
    output tri_ready_out, vec_valid_out, vec_x_out, vec_y_out, edge_idx_out,
           edge_last_out, busy_out, culled_out
  );

endinterface

`default_nettype wire

// File: rtl/edge_vec_sequencer_point_sub.sv
//------------------------------------------------------------------------------
// Module  : point_sub
// Brief   : Combinational point difference b - a, zero-extended to a signed vector.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module point_sub
  import fp3d_geom_pkg::*;
(
  input  point_t a,
  input  point_t b,
  output vec_t   d
);

  // One extra bit holds any difference of two W-bit unsigned values exactly.
  assign d.x = $signed({1'b0, b.x}) - $signed({1'b0, a.x});
  assign d.y = $signed({1'b0, b.y}) - $signed({1'b0, a.y});

endmodule

`default_nettype wire

// File: rtl/edge_vec_sequencer.sv
//------------------------------------------------------------------------------
// Module  : edge_vec_sequencer
// Brief   : Computes triangle edge vectors AB, BC, CA with one shared subtractor
//           and streams them out; EDGE_SEQ_CULL_EN adds back-face/degenerate cull.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module edge_vec_sequencer
  import fp3d_geom_pkg::*;
(
  input  wire                  clk_in,
  input  wire                  rst_n_in,
  edge_vec_sequencer_if.slave  bus
);

  seq_state_t state, state_nxt;
  logic [1:0] cnt;
  point_t     v0, v1, v2;
  vec_t       vbuf [3];
  point_t     sub_a, sub_b;
  vec_t       sub_d;
  logic       idle, emit, beat, last_cnt, culled;

  assign idle     = (state == IDLE);
  assign emit     = (state == EMIT);
  assign beat     = emit & bus.vec_ready_in;
  assign last_cnt = (cnt == 2'd2);

  // Operand selection walks the edges A->B, B->C, C->A.
  always_comb begin
    sub_a = v0;
    sub_b = v1;
    case (cnt)
      2'd1: begin sub_a = v1; sub_b = v2; end
      2'd2: begin sub_a = v2; sub_b = v0; end
      default: ;
    endcase
  end

  point_sub u_point_sub (
    .a (sub_a),
    .b (sub_b),
    .d (sub_d)
  );

`ifdef EDGE_SEQ_CULL_EN
  logic signed [AREA_W-1:0] area;
  logic                     area_pos;

  assign area     = sext_area(vbuf[0].x) * sext_area(vbuf[1].y)
                  - sext_area(vbuf[0].y) * sext_area(vbuf[1].x);
  assign area_pos = (area > 0);
  assign culled   = (state == AREA) & ~area_pos;
`else
  assign culled   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.tri_valid_in) state_nxt = CALC;
      CALC: begin
        if (last_cnt) begin
`ifdef EDGE_SEQ_CULL_EN
          state_nxt = AREA;
`else
          state_nxt = EMIT;
`endif
        end
      end
`ifdef EDGE_SEQ_CULL_EN
      AREA: state_nxt = area_pos ? EMIT : IDLE;
`else
      AREA: state_nxt = IDLE;
`endif
      EMIT: if (beat && last_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt     <= 2'd0;
      v0      <= '0;
      v1      <= '0;
      v2      <= '0;
      vbuf[0] <= '0;
      vbuf[1] <= '0;
      vbuf[2] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.tri_valid_in) begin
            v0  <= '{x: bus.v0_x_in, y: bus.v0_y_in};
            v1  <= '{x: bus.v1_x_in, y: bus.v1_y_in};
            v2  <= '{x: bus.v2_x_in, y: bus.v2_y_in};
            cnt <= 2'd0;
          end
        end
        CALC: begin
          vbuf[cnt] <= sub_d;
          cnt       <= last_cnt ? 2'd0 : cnt + 2'd1;
        end
        EMIT: begin
          if (beat) cnt <= last_cnt ? 2'd0 : cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.tri_ready_out = idle;
  assign bus.busy_out      = ~idle;
  assign bus.vec_valid_out = emit;
  assign bus.vec_x_out     = emit ? vbuf[cnt].x : '0;
  assign bus.vec_y_out     = emit ? vbuf[cnt].y : '0;
  assign bus.edge_idx_out  = emit ? edge_idx_t'(cnt) : EDGE_AB;
  assign bus.edge_last_out = emit & last_cnt;
  assign bus.culled_out    = culled;

endmodule

`default_nettype wire
